simon_key_schedule_ctrl: RTL and testbench

- Sequencer for the bit-serial, 3-share-compatible Simon key-schedule datapath: one 60-bit plus one 64-bit key FIFO, a 4-FF FIFO stage and a 4-FF LUT stage.
- Drives all datapath mux selects and enables, bit_counter, the round counter and the start/done handshake.
- Sits between the top-level cipher controller and the key-schedule datapath.
- Sequence: one 2*WORD-cycle serial key load, then ROUNDS rounds of WORD cycles each.

---
 rtl/simon_key_schedule_ctrl.sv | 147 ++++++++++++++
 tb/tb_simon_key_schedule_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_key_schedule_ctrl.sv
// Sequencer for the bit-serial Simon key-schedule datapath: serial key load, then ROUNDS x WORD run.
// Optional back-pressure input enabled by defining SIMON_KS_STALL_EN.
module simon_key_schedule_ctrl #(
    parameter int unsigned WORD   = 64,
    parameter int unsigned ROUNDS = 68,
    parameter int unsigned BCW    = 6,
    parameter int unsigned RCW    = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           data_in_valid,
`ifdef SIMON_KS_STALL_EN
    input  logic           stall,
`endif
    output logic [BCW-1:0] bit_counter,
    output logic [RCW-1:0] round_counter,
    output logic           round_lsb,
    output logic [1:0]     s1,
    output logic           s2,
    output logic [1:0]     s3,
    output logic           shifter_enable1,
    output logic           shifter_enable2,
    output logic           fifo_ff_enable,
    output logic           lut_ff_enable,
    output logic           key_valid,
    output logic           busy,
    output logic           done
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [BCW:0]   LOAD_LAST = (BCW+1)'(2*WORD-1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(WORD-1);
    localparam logic [BCW-1:0] BIT_TAIL  = BCW'(WORD-4);
    localparam logic [BCW-1:0] BIT_HEAD  = BCW'(4);
    localparam logic [RCW-1:0] RND_LAST  = RCW'(ROUNDS-1);

    state_t         state;
    logic [BCW:0]   load_cnt;
    logic [BCW-1:0] bit_cnt;
    logic [RCW-1:0] rnd_cnt;
    logic           run_go;
    logic           head;
    logic           tail;
    logic           first;

`ifdef SIMON_KS_STALL_EN
    assign run_go = ~stall;
`else
    assign run_go = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            load_cnt <= '0;
            bit_cnt  <= '0;
            rnd_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        load_cnt <= '0;
                        bit_cnt  <= '0;
                        rnd_cnt  <= '0;
                    end
                end
                LOAD: begin
                    if (data_in_valid) begin
                        if (load_cnt == LOAD_LAST) begin
                            state    <= RUN;
                            load_cnt <= '0;
                            bit_cnt  <= '0;
                            rnd_cnt  <= '0;
                        end else begin
                            load_cnt <= load_cnt + (BCW+1)'(1);
                        end
                    end
                end
                RUN: begin
                    if (run_go) begin
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            // Counters return to zero on the final wrap so they never exceed their range.
                            if (rnd_cnt == RND_LAST) begin
                                state   <= DONE;
                                rnd_cnt <= '0;
                            end else begin
                                rnd_cnt <= rnd_cnt + RCW'(1);
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BCW'(1);
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign head  = (bit_cnt < BIT_HEAD);
    assign tail  = (bit_cnt >= BIT_TAIL);
    assign first = (rnd_cnt == '0);

    always_comb begin
        s1              = 2'd1;
        s2              = 1'b0;
        s3              = 2'd1;
        shifter_enable1 = 1'b0;
        shifter_enable2 = 1'b0;
        fifo_ff_enable  = 1'b0;
        lut_ff_enable   = 1'b0;
        key_valid       = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        case (state)
            LOAD: begin
                busy            = 1'b1;
                shifter_enable1 = data_in_valid;
                shifter_enable2 = data_in_valid;
                fifo_ff_enable  = data_in_valid;
            end
            RUN: begin
                busy            = 1'b1;
                // Selects follow the counters only, so a stall holds them unchanged.
                s3              = (first || !head) ? 2'd2 : 2'd3;
                s1              = head ? (first ? 2'd0 : 2'd3) : 2'd2;
                s2              = !first && tail;
                shifter_enable1 = run_go;
                shifter_enable2 = run_go;
                key_valid       = run_go;
                fifo_ff_enable  = first && run_go;
                lut_ff_enable   = tail && run_go;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign bit_counter   = bit_cnt;
    assign round_counter = rnd_cnt;
    assign round_lsb     = rnd_cnt[0];

endmodule

// File: tb/tb_simon_key_schedule_ctrl.sv
// Randomized self-checking bench for simon_key_schedule_ctrl against a phase/time-index reference model.
module tb_simon_key_schedule_ctrl;

    localparam int WORD   = 64;
    localparam int ROUNDS = 68;
`ifdef SIMON_KS_STALL_EN
    localparam bit STALL_ON = 1'b1;
`else
    localparam bit STALL_ON = 1'b0;
`endif
    localparam logic [25:0] IDLE_OUTS = {6'd0, 7'd0, 1'b0, 2'd1, 1'b0, 2'd1, 7'b0};

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       data_in_valid;
`ifdef SIMON_KS_STALL_EN
    logic       stall_i;
`endif
    logic [5:0] bit_counter;
    logic [6:0] round_counter;
    logic       round_lsb;
    logic [1:0] s1;
    logic       s2;
    logic [1:0] s3;
    logic       shifter_enable1, shifter_enable2, fifo_ff_enable, lut_ff_enable;
    logic       key_valid, busy, done;
    logic [25:0] outs;

    simon_key_schedule_ctrl #(.WORD(64), .ROUNDS(68), .BCW(6), .RCW(7)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .data_in_valid(data_in_valid),
`ifdef SIMON_KS_STALL_EN
        .stall(stall_i),
`endif
        .bit_counter(bit_counter), .round_counter(round_counter), .round_lsb(round_lsb),
        .s1(s1), .s2(s2), .s3(s3),
        .shifter_enable1(shifter_enable1), .shifter_enable2(shifter_enable2),
        .fifo_ff_enable(fifo_ff_enable), .lut_ff_enable(lut_ff_enable),
        .key_valid(key_valid), .busy(busy), .done(done)
    );

    assign outs = {bit_counter, round_counter, round_lsb, s1, s2, s3,
                   shifter_enable1, shifter_enable2, fifo_ff_enable, lut_ff_enable,
                   key_valid, busy, done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: phase (0 idle, 1 load, 2 run, 3 done), bits loaded, run time index.
    int m_mode = 0;
    int m_lcnt = 0;
    int m_t    = 0;

    int cyc = 0;
    int start_cyc, run_start_cyc, done_cyc, load_cycles, shift_cnt, max_rc;
    bit prev_run;
    logic [25:0] last_outs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [25:0] expect_outs(input int m, input int t, input logic dv, input logic es);
        int r, b;
        logic [5:0] bc;
        logic [6:0] rc;
        logic [1:0] s1e, s3e;
        logic s2e, e1, e2, ff, lf, kv, bz, dn;
        bc = '0; rc = '0; s1e = 2'd1; s3e = 2'd1; s2e = 1'b0;
        e1 = 1'b0; e2 = 1'b0; ff = 1'b0; lf = 1'b0; kv = 1'b0; bz = 1'b0; dn = 1'b0;
        if (m == 1) begin
            bz = 1'b1; e1 = dv; e2 = dv; ff = dv;
        end else if (m == 2) begin
            r = t / WORD;
            b = t % WORD;
            bc = b[5:0];
            rc = r[6:0];
            bz = 1'b1;
            s3e = (r == 0 || b >= 4) ? 2'd2 : 2'd3;
            s1e = (b < 4) ? ((r == 0) ? 2'd0 : 2'd3) : 2'd2;
            s2e = (r > 0 && b >= WORD-4);
            e1 = !es; e2 = !es; kv = !es;
            ff = (r == 0) && !es;
            lf = (b >= WORD-4) && !es;
        end else if (m == 3) begin
            dn = 1'b1;
        end
        return {bc, rc, rc[0], s1e, s2e, s3e, e1, e2, ff, lf, kv, bz, dn};
    endfunction

    task automatic step(input logic st, input logic dv, input logic rn, input logic sl);
        logic es;
        logic in_run;
        @(negedge clk);
        start = st;
        data_in_valid = dv;
        rst_n = rn;
`ifdef SIMON_KS_STALL_EN
        stall_i = sl;
`endif
        es = sl & STALL_ON;
        #1;
        check("outs", outs, expect_outs(m_mode, m_t, dv, es));
        last_outs = outs;
        cyc++;
        in_run = busy && (s1 != 2'd1);
        if (done) done_cyc = cyc;
        if (busy && s1 == 2'd1) load_cycles++;
        if (busy && s1 == 2'd1 && shifter_enable1) shift_cnt++;
        if (in_run && !prev_run) run_start_cyc = cyc;
        if (in_run && int'(round_counter) > max_rc) max_rc = int'(round_counter);
        prev_run = in_run;
        if (m_mode == 2 && !es) begin
            if (m_t == 2)
                check("dec_r0b2", {s1, s3, s2, fifo_ff_enable}, {2'd0, 2'd2, 1'b0, 1'b1});
            if (m_t == 5*WORD+2)
                check("dec_r5b2", {s1, s3}, {2'd3, 2'd3});
            if (m_t == 5*WORD+61)
                check("dec_r5b61", {s1, s2, lut_ff_enable}, {2'd2, 1'b1, 1'b1});
        end
        @(posedge clk);
        if (!rn) begin
            m_mode = 0; m_lcnt = 0; m_t = 0;
        end else begin
            case (m_mode)
                0: if (st) begin m_mode = 1; m_lcnt = 0; end
                1: if (dv) begin
                    m_lcnt++;
                    if (m_lcnt == 2*WORD) begin m_mode = 2; m_t = 0; end
                end
                2: if (!es) begin
                    m_t++;
                    if (m_t == ROUNDS*WORD) begin m_mode = 3; m_t = 0; end
                end
                default: m_mode = 0;
            endcase
        end
    endtask

    task automatic clear_stats();
        start_cyc = 0; run_start_cyc = -1; done_cyc = -1;
        load_cycles = 0; shift_cnt = 0; max_rc = 0; prev_run = 1'b0;
    endtask

    // Steps until done is observed or the budget runs out; rnd adds random valid gaps, starts and stalls.
    task automatic drive(input int budget, input bit rnd);
        bit fin;
        fin = 1'b0;
        for (int i = 0; i < budget && !fin; i++) begin
            if (rnd)
                step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, 1'b1, $urandom_range(0, 3) == 0);
            else
                step(1'b0, 1'b1, 1'b1, 1'b0);
            fin = last_outs[0];
        end
        if (!fin) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        start = 1'b0; data_in_valid = 1'b0; rst_n = 1'b0;
`ifdef SIMON_KS_STALL_EN
        stall_i = 1'b0;
`endif
        clear_stats();
        @(posedge clk);

        // Reset held with start asserted
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("reset_state", last_outs, IDLE_OUTS);

        // Full run without gaps
        clear_stats();
        step(1'b1, 1'b0, 1'b1, 1'b0);
        start_cyc = cyc;
        drive(5000, 1'b0);
        check("run_entry", run_start_cyc - start_cyc, 129);
        check("run_len", done_cyc - run_start_cyc, ROUNDS*WORD);
        check("max_round", max_rc, ROUNDS-1);
        check("load_shifts", shift_cnt, 2*WORD);

        // Load with a 10-cycle valid gap
        clear_stats();
        step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (60) step(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (10) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            check("gap_en", {shifter_enable1, shifter_enable2, fifo_ff_enable}, 3'b000);
        end
        drive(5000, 1'b0);
        check("gap_load_len", load_cycles, 138);
        check("gap_shifts", shift_cnt, 2*WORD);
        check("gap_run_len", done_cyc - run_start_cyc, ROUNDS*WORD);

        // Abort at r=10, b=30 (start coincident with reset must be ignored)
        clear_stats();
        step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (2*WORD) step(1'b0, 1'b1, 1'b1, 1'b0);
        while (m_mode == 2 && m_t < 10*WORD+30) step(1'b0, 1'b0, 1'b1, 1'b0);
        check("abort_point", {round_counter, bit_counter}, {7'd10, 6'd29});
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("abort_idle", last_outs, IDLE_OUTS);
        check("abort_nodone", done_cyc, -1);
        clear_stats();
        step(1'b1, 1'b0, 1'b1, 1'b0);
        drive(5000, 1'b0);
        check("rerun_len", done_cyc - run_start_cyc, ROUNDS*WORD);

`ifdef SIMON_KS_STALL_EN
        // Five stall cycles at r=3, b=63
        clear_stats();
        step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (2*WORD) step(1'b0, 1'b1, 1'b1, 1'b0);
        while (m_mode == 2 && m_t < 3*WORD+63) step(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (5) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            check("stall_hold", {round_counter, bit_counter}, {7'd3, 6'd63});
        end
        drive(5000, 1'b0);
        check("stall_run_len", done_cyc - run_start_cyc, ROUNDS*WORD + 5);
`endif

        // Randomized runs: valid gaps, stray starts while busy, random stalls
        repeat (2) begin
            clear_stats();
            step(1'b1, 1'b0, 1'b1, 1'b0);
            drive(20000, 1'b1);
            repeat ($urandom_range(1, 4)) step(1'b0, 1'b0, 1'b1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
